deskew8: RTL
============

# deskew8

Multi-lane deskew/realignment block: the receive-side counterpart of the per-lane selectable-tap delay (`shift8`-style) used in the Memory/Shifter group. Each lane arrives delayed upstream by a known 0..MAX_DLY clock cycles. This block delays each lane by the complement, so all lanes present bytes from the same source cycle together with a matching valid. It sits between the skewed lane fabric and the word-level consumer.

## Interface

Parameters:
- `LANES`, 4, number of byte lanes
- `WIDTH`, 8, bits per lane
- `MAX_DLY`, 3, maximum upstream skew in cycles
- `SW`, $clog2(MAX_DLY+1), width of one skew field (derived)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_data`  in  LANES*WIDTH  skewed lane data; lane i = `in_data[i*WIDTH +: WIDTH]`
- `in_valid`  in  1  source-frame valid, unskewed (aligned to a skew-0 lane)
- `skew`  in  LANES*SW  upstream delay of lane i = `skew[i*SW +: SW]`
- `cfg_load`  in  1  capture `skew` into the active configuration
- `out_data`  out  LANES*WIDTH  realigned word
- `out_valid`  out  1  `out_data` is a complete aligned frame
- `busy`  out  1  flush in progress after reconfiguration

## Operation

- Each lane has MAX_DLY+1 register stages. The lane i tap is chosen so total delay = MAX_DLY − skew_q[i] + 1 cycles (registered output).
- `in_valid` passes through a fixed MAX_DLY+1 stage valid pipe.
- Source frame at cycle t, with lane i driven at t+skew_i, appears complete on `out_data` at cycle t+MAX_DLY+1.
- On `cfg_load`, `skew_q` is loaded at the next edge. Skew fields > MAX_DLY are clamped to MAX_DLY.
- Flush counter: loaded with MAX_DLY+1 on `cfg_load` and decremented each cycle to 0.
  - `busy` = (counter != 0).
  - While busy, `out_valid` is forced to 0. The data and valid pipes keep shifting.
  - `cfg_load` while busy reloads the counter and restarts the flush.
- Data pipes are not gated by `in_valid`. Stages are free-running, as in the shift chain.
- Reset (rst_n=0 at an edge) clears all stages, `out_data`=0, `out_valid`=0, `skew_q`=0, counter=0, `busy`=0. Reset wins over simultaneous `cfg_load`. Reset mid-stream drops all in-flight frames.

## Timing

- Latency: `in_valid` → `out_valid` is exactly MAX_DLY+1 cycles. Lane latency is MAX_DLY−skew_i+1.
- `cfg_load` asserted at edge k: new skews are used from edge k+1. `busy` is high for cycles k+1..k+MAX_DLY+1. `out_valid` may rise at k+MAX_DLY+2 at the earliest.
- No back-pressure. The consumer must accept every `out_valid` cycle.
- All outputs are registered. No combinational input-to-output path.

## Configuration

- Macro: `DESKEW8_SKEW_ERR_EN`.
- Defined: adds output port `skew_err` (1 bit, reset 0).
  - Sticky set on any `cfg_load` carrying a skew field > MAX_DLY.
  - Cleared only by reset.
  - The clamp still applies.
- Undefined: no `skew_err` port. Out-of-range fields are silently clamped.

## Structure

- Package `deskew8_pkg` holds default constants: DESKEW_LANES=4, DESKEW_WIDTH=8, DESKEW_MAX_DLY=3.
- Sub-module `deskew_lane`: one lane's MAX_DLY+1-stage register chain plus registered tap mux. It is instantiated LANES times via generate.
- The top level owns `skew_q`, the valid pipe, the flush counter, clamp and error logic.

## Test plan

All scenarios use the default parameters.

- Reset: hold rst_n=0 for 3 cycles with random inputs → `out_data`=0, `out_valid`=0, `busy`=0. Then release with zero skews and frames 0x11..0x14 on all lanes → the same frames appear 4 cycles later with `out_valid`=1.
- Skewed stream: load skew {lane3..0}={3,2,1,0}, wait for `busy`=0. Drive frame n = byte 0x20+n on every lane, lane i delayed i cycles, `in_valid` for n=0..7 → `out_data`=0x20202020..0x27272727 on 8 consecutive cycles, 4 cycles after each frame's `in_valid`.
- Flush: `cfg_load` mid-stream → `busy` high exactly 4 cycles and `out_valid`=0 throughout. The next valid word uses the new skews.
- Back-to-back reconfiguration: `cfg_load` at cycles k and k+2 → `busy` stays high through k+6 and `out_valid` stays 0 through k+6.
- Clamp: instantiate with MAX_DLY=2 (SW=2) and load lane0 skew=3 → lane0 behaves as skew 2. With `DESKEW8_SKEW_ERR_EN`, `skew_err`=1 from the next cycle until reset.
- Reset mid-stream: assert rst_n=0 for 1 cycle during the skewed stream → the next cycle shows `out_valid`=0 and `out_data`=0, and `skew_q` returns to 0.

Source files
------------

// File: rtl/deskew8_pkg.sv
// Default constants shared by the deskew8 top and its lane sub-module.
package deskew8_pkg;
  localparam int DESKEW_LANES   = 4;
  localparam int DESKEW_WIDTH   = 8;
  localparam int DESKEW_MAX_DLY = 3;
endpackage

// File: rtl/deskew_lane.sv
// One deskew lane: free-running MAX_DLY-stage shift chain feeding a registered tap mux.
module deskew_lane #(
  parameter int WIDTH   = 8,
  parameter int MAX_DLY = 3,
  parameter int SW      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    skew,
  output logic [WIDTH-1:0] dout
);
  logic [MAX_DLY-1:0][WIDTH-1:0] stg;
  logic [MAX_DLY:0][WIDTH-1:0]   taps;
  logic [SW-1:0]                 sel;
  logic [WIDTH-1:0]              tap;

  // taps[j] is din delayed j cycles; the output register adds the final cycle.
  assign taps = {stg, din};
  assign sel  = SW'(MAX_DLY) - skew;

  always_comb begin
    tap = '0;
    for (int j = 0; j <= MAX_DLY; j++)
      if (sel == SW'(j)) tap = taps[j];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg  <= '0;
      dout <= '0;
    end else begin
      stg[0] <= din;
      for (int j = 1; j < MAX_DLY; j++) stg[j] <= stg[j-1];
      dout <= tap;
    end
  end
endmodule

// File: rtl/deskew8.sv
// Multi-lane deskew: per-lane complementary delay, fixed valid pipe, flush after reconfig.
// Optional DESKEW8_SKEW_ERR_EN adds a sticky skew_err output for out-of-range skew loads.
module deskew8 import deskew8_pkg::*; #(
  parameter int LANES   = DESKEW_LANES,
  parameter int WIDTH   = DESKEW_WIDTH,
  parameter int MAX_DLY = DESKEW_MAX_DLY,
  parameter int SW      = $clog2(MAX_DLY+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  input  logic [LANES*SW-1:0]    skew,
  input  logic                   cfg_load,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  output logic                   busy
`ifdef DESKEW8_SKEW_ERR_EN
  , output logic                 skew_err
`endif
);
  localparam int CW = $clog2(MAX_DLY+2);

  logic [LANES-1:0][SW-1:0] fld, clmp, skew_q;
  logic [MAX_DLY-1:0]       vld_pipe;
  logic [CW-1:0]            cnt, cnt_nxt;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      assign fld[i]  = skew[i*SW +: SW];
      assign clmp[i] = (32'(fld[i]) > MAX_DLY) ? SW'(MAX_DLY) : fld[i];
      deskew_lane #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY), .SW(SW)) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (in_data[i*WIDTH +: WIDTH]),
        .skew (skew_q[i]),
        .dout (out_data[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // out_valid is gated by the next counter value so it is never high in a busy cycle.
  always_comb begin
    cnt_nxt = cnt;
    if (cfg_load)       cnt_nxt = CW'(MAX_DLY+1);
    else if (cnt != '0) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skew_q    <= '0;
      vld_pipe  <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
    end else begin
      if (cfg_load) skew_q <= clmp;
      vld_pipe[0] <= in_valid;
      for (int j = 1; j < MAX_DLY; j++) vld_pipe[j] <= vld_pipe[j-1];
      out_valid <= vld_pipe[MAX_DLY-1] && (cnt_nxt == '0);
      cnt       <= cnt_nxt;
      busy      <= (cnt_nxt != '0);
    end
  end

`ifdef DESKEW8_SKEW_ERR_EN
  logic any_over;
  always_comb begin
    any_over = 1'b0;
    for (int j = 0; j < LANES; j++)
      if (32'(fld[j]) > MAX_DLY) any_over = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                    skew_err <= 1'b0;
    else if (cfg_load && any_over) skew_err <= 1'b1;
  end
`endif
endmodule
